// File: rtl/fifo_pkg.sv
// Shared definitions for the narrow-write / wide-read FIFO.
package fifo_pkg;

    // Request classification, encoded as {rd, wr}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_RDWR = 2'b11
    } fifo_op_t;

    // Width of one read pair: two stored words side by side.
    function automatic int pair_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/fifo_wide_rd_ctrl.sv
// Pointer, occupancy and status-flag controller for fifo_wide_rd.
//
// Request semantics: rd and wr are single-cycle requests with no handshake
// back-pressure signal. Each is judged on the pre-edge occupancy only: a write
// is accepted when the FIFO is not full, a read (popping two words) when at
// least two words are held. Rejected requests are dropped without side effect.
// While reset is high both requests are ignored.
module fifo_wide_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr0,
    output logic [ADDR_WIDTH-1:0] r_addr1,
    output logic                  w_en,
    output logic                  empty,
    output logic                  one_entry,
    output logic                  full
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   C_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   C_TWO   = (ADDR_WIDTH + 1)'(2);
    localparam logic [ADDR_WIDTH-1:0] P_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] P_TWO   = ADDR_WIDTH'(2);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_empty;
    logic                  r_one_entry;
    logic                  r_full;

    logic                  w_write_ok;
    logic                  w_read_ok;
    fifo_op_t              w_op;
    logic [ADDR_WIDTH:0]   w_count_next;

    // Acceptance uses only the pre-edge count, so a same-cycle read never
    // makes room for a write.
    assign w_write_ok = wr & (r_count != C_DEPTH);
    assign w_read_ok  = rd & (r_count >= C_TWO);
    assign w_op       = fifo_op_t'({w_read_ok, w_write_ok});

    // Next occupancy from the accepted operation mix.
    always_comb begin
        w_count_next = r_count;
        case (w_op)
            OP_WR:   w_count_next = r_count + C_ONE;
            OP_RD:   w_count_next = r_count - C_TWO;
            OP_RDWR: w_count_next = r_count - C_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, count and registered flags; reset discards all queued data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_one_entry <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            if (w_write_ok) r_wr_ptr <= r_wr_ptr + P_ONE;
            if (w_read_ok)  r_rd_ptr <= r_rd_ptr + P_TWO;
            r_count     <= w_count_next;
            r_empty     <= (w_count_next == '0);
            r_one_entry <= (w_count_next == C_ONE);
            r_full      <= (w_count_next == C_DEPTH);
        end
    end

    assign w_addr    = r_wr_ptr;
    assign r_addr0   = r_rd_ptr;
    assign r_addr1   = r_rd_ptr + P_ONE;
    assign w_en      = w_write_ok & ~reset;
    assign empty     = r_empty;
    assign one_entry = r_one_entry;
    assign full      = r_full;

endmodule

// File: rtl/fifo_wide_rd.sv
// Circular FIFO taking single-word writes and delivering two-word reads,
// oldest word in the LSBs of r_data.
module fifo_wide_rd
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rd,
    input  logic                                wr,
    input  logic [DATA_WIDTH-1:0]               w_data,
    output logic [pair_width(DATA_WIDTH)-1:0]   r_data,
    output logic                                empty,
    output logic                                one_entry,
    output logic                                full
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_raddr0;
    logic [ADDR_WIDTH-1:0] w_raddr1;
    logic                  w_we;

    fifo_wide_rd_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .rd        (rd),
        .wr        (wr),
        .w_addr    (w_addr),
        .r_addr0   (w_raddr0),
        .r_addr1   (w_raddr1),
        .w_en      (w_we),
        .empty     (empty),
        .one_entry (one_entry),
        .full      (full)
    );

    // Synchronous write port; storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_addr] <= w_data;
    end

    // Asynchronous pair read; the rd_ptr+1 address wraps naturally.
    assign r_data = {r_mem[w_raddr1], r_mem[w_raddr0]};

endmodule

// File: tb/tb_fifo_wide_rd.sv
// Self-checking bench for fifo_wide_rd (DATA_WIDTH=8, ADDR_WIDTH=2).
module tb_fifo_wide_rd;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          rd;
    logic          wr;
    logic [DW-1:0] w_data;
    logic [2*DW-1:0] r_data;
    logic          empty;
    logic          one_entry;
    logic          full;

    fifo_wide_rd #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd        (rd),
        .wr        (wr),
        .w_data    (w_data),
        .r_data    (r_data),
        .empty     (empty),
        .one_entry (one_entry),
        .full      (full)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          rd;
        bit          wr;
        logic [7:0]  d;
        bit          e;
        bit          o;
        bit          f;
    } vec_t;

    vec_t vecs[$];

    logic [DW-1:0]   model_q[$];
    logic [2*DW-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    function automatic void add(input bit rst, input bit r, input bit w,
                                input logic [7:0] d,
                                input bit e, input bit o, input bit f);
        vec_t v;
        v.rst = rst; v.rd = r; v.wr = w; v.d = d;
        v.e = e; v.o = o; v.f = f;
        vecs.push_back(v);
    endfunction

    // Drive one cycle, score reads against the model, check flags afterwards.
    task automatic step(input int idx, input bit rst, input bit r, input bit w,
                        input logic [7:0] d, input bit e, input bit o, input bit f);
        bit rok;
        bit wok;
        logic [15:0] got;
        @(negedge clk);
        reset = rst; rd = r; wr = w; w_data = d;
        rok = !rst && r && (model_q.size() >= 2);
        wok = !rst && w && (model_q.size() != DEPTH);
        #1;
        if (rok) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = model_q.pop_front();
            hi = model_q.pop_front();
            exp_q.push_back({hi, lo});
            got = r_data;
            chk("r_data", idx, got, exp_q.pop_front());
        end
        if (rst) model_q.delete();
        if (wok) model_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
        chk("empty", idx, {15'd0, empty}, {15'd0, e});
        chk("one_entry", idx, {15'd0, one_entry}, {15'd0, o});
        chk("full", idx, {15'd0, full}, {15'd0, f});
        reset = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0; w_data = '0;

        // Reset, then a rejected read
        add(1, 0, 0, 8'h00, 1, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 0);
        // Single-entry block
        add(0, 0, 1, 8'hA1, 0, 1, 0);
        add(0, 1, 0, 8'h00, 0, 1, 0);
        add(0, 0, 1, 8'hB2, 0, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 0);
        // Fill and overflow
        add(0, 0, 1, 8'h11, 0, 1, 0);
        add(0, 0, 1, 8'h22, 0, 0, 0);
        add(0, 0, 1, 8'h33, 0, 0, 0);
        add(0, 0, 1, 8'h44, 0, 0, 1);
        add(0, 0, 1, 8'h55, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 0);
        // Wrap-around
        add(0, 0, 1, 8'h01, 0, 1, 0);
        add(0, 0, 1, 8'h02, 0, 0, 0);
        add(0, 0, 1, 8'h03, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 0);
        add(0, 0, 1, 8'h04, 0, 0, 0);
        add(0, 0, 1, 8'h05, 0, 0, 0);
        add(0, 0, 1, 8'h06, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 0);
        // Simultaneous requests
        add(0, 0, 1, 8'hD0, 0, 1, 0);
        add(0, 0, 1, 8'hD1, 0, 0, 0);
        add(0, 0, 1, 8'hD2, 0, 0, 0);
        add(0, 0, 1, 8'hD3, 0, 0, 1);
        add(0, 1, 1, 8'hEE, 0, 0, 0);   // full: write dropped
        add(0, 1, 0, 8'h00, 1, 0, 0);
        add(0, 0, 1, 8'h5A, 0, 1, 0);
        add(0, 1, 1, 8'h5B, 0, 0, 0);   // one entry: read dropped
        add(0, 1, 1, 8'h5C, 0, 1, 0);   // count 2: both accepted
        add(0, 0, 1, 8'h5D, 0, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 0);
        // Reset mid-stream with both requests high
        add(0, 0, 1, 8'h61, 0, 1, 0);
        add(0, 0, 1, 8'h62, 0, 0, 0);
        add(0, 0, 1, 8'h63, 0, 0, 0);
        add(1, 1, 1, 8'h64, 1, 0, 0);
        add(0, 0, 1, 8'hC1, 0, 1, 0);
        add(0, 0, 1, 8'hC2, 0, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].d,
                 vecs[i].e, vecs[i].o, vecs[i].f);
        end

        // Random traffic; expected flags come from the word-queue model
        for (int i = 0; i < 400; i++) begin
            bit rs;
            bit rr;
            bit ww;
            logic [7:0] dd;
            int sz;
            rs = ($urandom_range(0, 49) == 0);
            rr = $urandom_range(0, 1);
            ww = $urandom_range(0, 1);
            dd = 8'($urandom_range(0, 255));
            sz = model_q.size();
            if (rs) sz = 0;
            else begin
                if (ww && sz != DEPTH) sz++;
                if (rr && model_q.size() >= 2) sz -= 2;
            end
            step(1000 + i, rs, rr, ww, dd, sz == 0, sz == 1, sz == DEPTH);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
